// File: rtl/picnic_verify_pkg.sv
// Shared constants and types for the Picnic-on-SM4 verify round sequencer.
package picnic_verify_pkg;

   localparam int T        = 250;
   localparam int DIGEST_W = 256;

   localparam logic [1:0] SEL_CH = 2'd0;
   localparam logic [1:0] SEL_CN = 2'd1;
   localparam logic [1:0] SEL_CV = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ISSUE,
      EMIT_CH,
      EMIT_CN,
      EMIT_CV,
      RELEASE,
      DONE
   } seq_state_e;

endpackage

// File: rtl/digest_emit_buf.sv
// Three-entry latch-and-shift holding one round's Ch/Cn/Cv digests and
// presenting them in order on a valid/ready port tagged with their selector.
module digest_emit_buf #(
   parameter int DIGEST_W = picnic_verify_pkg::DIGEST_W
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                load_i,
   input  logic [DIGEST_W-1:0] ch_i,
   input  logic [DIGEST_W-1:0] cn_i,
   input  logic [DIGEST_W-1:0] cv_i,
   input  logic [7:0]          t_i,
   input  logic                last_i,
   input  logic                ready_i,
   output logic                valid_o,
   output logic [DIGEST_W-1:0] data_o,
   output logic [1:0]          sel_o,
   output logic [7:0]          t_o,
   output logic                last_o
);
   import picnic_verify_pkg::*;

   logic [1:0]          cnt_q;
   logic                last_q;
   logic [DIGEST_W-1:0] e0_q, e1_q, e2_q;
   logic [7:0]          t_q;
   logic                hs;

   assign hs = valid_o && ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= 2'd0;
         last_q <= 1'b0;
      end else if (load_i) begin
         cnt_q  <= 2'd3;
         last_q <= last_i;
      end else if (hs) begin
         cnt_q  <= cnt_q - 2'd1;
      end
   end

   // Payload registers carry no reset; outputs are gated by valid instead.
   always_ff @(posedge clk_i) begin
      if (load_i) begin
         e0_q <= ch_i;
         e1_q <= cn_i;
         e2_q <= cv_i;
         t_q  <= t_i;
      end else if (hs) begin
         e0_q <= e1_q;
         e1_q <= e2_q;
      end
   end

   always_comb begin
      sel_o = SEL_CH;
      case (cnt_q)
         2'd2:    sel_o = SEL_CN;
         2'd1:    sel_o = SEL_CV;
         default: sel_o = SEL_CH;
      endcase
   end

   assign valid_o = (cnt_q != 2'd0);
   assign data_o  = valid_o ? e0_q : '0;
   assign t_o     = valid_o ? t_q : 8'd0;
   assign last_o  = last_q && (cnt_q == 2'd1);

endmodule

// File: rtl/verify_round_sequencer.sv
// Sequences the per-round verify function over all T repetitions and streams
// each round's Ch/Cn/Cv digests to the challenge-hash stage.
module verify_round_sequencer #(
   parameter int T        = picnic_verify_pkg::T,
   parameter int DIGEST_W = picnic_verify_pkg::DIGEST_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                seq_start,
   input  logic [T-1:0]        challenge_mask,
   input  logic [7:0]          j_lookup,
   input  logic                round_end,
   input  logic [DIGEST_W-1:0] round_ch,
   input  logic [DIGEST_W-1:0] round_cn,
   input  logic [DIGEST_W-1:0] round_cv,
   output logic                round_start,
   output logic [7:0]          round_t,
   output logic                round_t_in_LC,
   output logic [7:0]          round_j,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DIGEST_W-1:0] out_data,
   output logic [1:0]          out_sel,
   output logic [7:0]          out_t,
   output logic                out_last,
   output logic                busy,
   output logic                done,
   output logic [7:0]          opened_count
);
   import picnic_verify_pkg::*;

   localparam logic [7:0] T_LAST = 8'(T - 1);

   seq_state_e  state_q, state_d;
   logic [T-1:0] mask_q, mask_d;
   logic [7:0]  t_q, t_d;
   logic [7:0]  j_q, j_d;
   logic        lc_q, lc_d;
   logic [7:0]  opened_q, opened_d;
   logic        load_buf;
   logic        hs;
   logic        mask_hit;

   assign hs       = out_valid && out_ready;
   assign mask_hit = |(mask_q & (T'(1'b1) << t_q));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         mask_q   <= '0;
         t_q      <= 8'd0;
         j_q      <= 8'd0;
         lc_q     <= 1'b0;
         opened_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         t_q      <= t_d;
         j_q      <= j_d;
         lc_q     <= lc_d;
         opened_q <= opened_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      t_d      = t_q;
      j_d      = j_q;
      lc_d     = lc_q;
      opened_d = opened_q;
      load_buf = 1'b0;
      case (state_q)
         IDLE: if (seq_start) begin
            mask_d   = challenge_mask;
            t_d      = 8'd0;
            opened_d = 8'd0;
            state_d  = LOAD;
         end
         LOAD: begin
            j_d     = j_lookup;
            lc_d    = mask_hit;
            state_d = ISSUE;
         end
         // A round_end already high on entry is accepted as this round's result.
         ISSUE: if (round_end) begin
            load_buf = 1'b1;
            if (lc_q) opened_d = opened_q + 8'd1;
            state_d  = EMIT_CH;
         end
         EMIT_CH: if (hs) state_d = EMIT_CN;
         EMIT_CN: if (hs) state_d = EMIT_CV;
         EMIT_CV: if (hs) state_d = RELEASE;
         RELEASE: if (!round_end) begin
            if (t_q == T_LAST) begin
               state_d = DONE;
            end else begin
               t_d     = t_q + 8'd1;
               state_d = LOAD;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   digest_emit_buf #(.DIGEST_W(DIGEST_W)) u_emit (
      .clk_i   (clk),
      .rst_ni  (reset),
      .load_i  (load_buf),
      .ch_i    (round_ch),
      .cn_i    (round_cn),
      .cv_i    (round_cv),
      .t_i     (t_q),
      .last_i  (t_q == T_LAST),
      .ready_i (out_ready),
      .valid_o (out_valid),
      .data_o  (out_data),
      .sel_o   (out_sel),
      .t_o     (out_t),
      .last_o  (out_last)
   );

   assign round_start    = (state_q == ISSUE);
   assign round_t        = t_q;
   assign round_j        = j_q;
   assign round_t_in_LC  = lc_q;
   assign opened_count   = opened_q;
   assign busy           = (state_q != IDLE) && (state_q != DONE);
   assign done           = (state_q == DONE);

endmodule

// File: tb/tb_verify_round_sequencer.sv
// Directed bench for verify_round_sequencer: a T=4 instance driven by a small
// round-function model and sink monitor, plus a T=1 instance driven by hand.
module tb_verify_round_sequencer;
   localparam int DW = 256;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // ---------------- T = 4 instance ----------------
   logic          seq4  = 1'b0;
   logic [3:0]    mask4 = 4'b0000;
   logic [7:0]    j4;
   logic          re4   = 1'b0;
   logic [DW-1:0] ch4, cn4, cv4;
   logic          rs4, inlc4, ov4, ol4, busy4, done4;
   logic          or4   = 1'b0;
   logic [7:0]    rt4, rj4, ot4, oc4;
   logic [DW-1:0] od4;
   logic [1:0]    os4;

   assign j4  = rt4 + 8'h0B;
   assign ch4 = {8'hC4, 240'h0, rt4};
   assign cn4 = {8'hE4, 240'h0, rt4};
   assign cv4 = {8'hF4, 240'h0, rt4};

   verify_round_sequencer #(.T(4), .DIGEST_W(DW)) dut4 (
      .clk(clk), .reset(rst_n), .seq_start(seq4), .challenge_mask(mask4),
      .j_lookup(j4), .round_end(re4), .round_ch(ch4), .round_cn(cn4), .round_cv(cv4),
      .round_start(rs4), .round_t(rt4), .round_t_in_LC(inlc4), .round_j(rj4),
      .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_sel(os4), .out_t(ot4),
      .out_last(ol4), .busy(busy4), .done(done4), .opened_count(oc4)
   );

   // ---------------- T = 1 instance ----------------
   logic          seq1  = 1'b0;
   logic [0:0]    mask1 = 1'b0;
   logic [7:0]    j1;
   logic          re1   = 1'b0;
   logic [DW-1:0] ch1, cn1, cv1;
   logic          rs1, inlc1, ov1, ol1, busy1, done1;
   logic          or1   = 1'b1;
   logic [7:0]    rt1, rj1, ot1, oc1;
   logic [DW-1:0] od1;
   logic [1:0]    os1;

   assign j1  = rt1 + 8'h0B;
   assign ch1 = {8'hC4, 240'h0, 8'h00};
   assign cn1 = {8'hE4, 240'h0, 8'h00};
   assign cv1 = {8'hF4, 240'h0, 8'h00};

   verify_round_sequencer #(.T(1), .DIGEST_W(DW)) dut1 (
      .clk(clk), .reset(rst_n), .seq_start(seq1), .challenge_mask(mask1),
      .j_lookup(j1), .round_end(re1), .round_ch(ch1), .round_cn(cn1), .round_cv(cv1),
      .round_start(rs1), .round_t(rt1), .round_t_in_LC(inlc1), .round_j(rj1),
      .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_sel(os1), .out_t(ot1),
      .out_last(ol1), .busy(busy1), .done(done1), .opened_count(oc1)
   );

   // ---------------- monitor + round-function model for dut4 ----------------
   int  cyc = 0;
   int  hold_extra = 0;
   bit  ready_mode = 1'b0;
   int  rcnt = 0, hcnt = 0;
   logic [DW-1:0] bd[$];
   logic [1:0]    bs[$];
   logic [7:0]    bt[$];
   logic          bl[$];
   int  done_cnt = 0, stall_err = 0, rise_viol = 0, j_err = 0;
   logic [3:0] inlc_seen = 4'b0000;
   logic [7:0] oc_at_done = 8'd0, rt_first = 8'hFF;
   int  rs_first = -1, ov_first = -1, re_set = -1, last_re_set = -100, re_fall = -100;
   int  seq_cyc = 0;
   logic pv = 1'b0, pr = 1'b0, pl = 1'b0, prs = 1'b0;
   logic [DW-1:0] pd = '0;
   logic [1:0] ps = 2'd0;
   logic [7:0] pt = 8'd0;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         re4 = 1'b0; rcnt = 0; hcnt = 0; or4 = 1'b0; pv = 1'b0; prs = 1'b0;
      end else begin
         or4 = ready_mode ? cyc[0] : 1'b1;
         if (pv && !pr && (!ov4 || od4 !== pd || os4 !== ps || ot4 !== pt || ol4 !== pl))
            stall_err++;
         if (ov4 && or4) begin
            bd.push_back(od4); bs.push_back(os4); bt.push_back(ot4); bl.push_back(ol4);
         end
         if (done4) begin done_cnt++; oc_at_done = oc4; end
         if (rs4 && !prs) begin
            if (re4 || (cyc - re_fall) < 2 || (cyc - last_re_set) < 6) rise_viol++;
            if (rs_first < 0) begin rs_first = cyc; rt_first = rt4; end
            inlc_seen[rt4[1:0]] = inlc4;
            if (rj4 !== rt4 + 8'h0B) j_err++;
         end
         if (ov4 && ov_first < 0) ov_first = cyc;
         pv = ov4; pr = or4; pd = od4; ps = os4; pt = ot4; pl = ol4; prs = rs4;
         if (re4) begin
            if (!rs4) begin
               if (hcnt >= hold_extra) begin re4 = 1'b0; re_fall = cyc; end
               else hcnt++;
            end
         end else if (rs4) begin
            rcnt++;
            if (rcnt >= 10) begin
               re4 = 1'b1; rcnt = 0; hcnt = 0; last_re_set = cyc;
               if (re_set < 0) re_set = cyc;
            end
         end else begin
            rcnt = 0;
         end
      end
   end

   function automatic logic [DW-1:0] exp_data(input int t, input int s);
      logic [7:0] tag;
      tag = (s == 0) ? 8'hC4 : (s == 1) ? 8'hE4 : 8'hF4;
      return {tag, 240'h0, 8'(t)};
   endfunction

   task automatic start_pass(input logic [3:0] m);
      @(negedge clk); #1;
      bd.delete(); bs.delete(); bt.delete(); bl.delete();
      done_cnt = 0; stall_err = 0; rise_viol = 0; j_err = 0; inlc_seen = 4'b0000;
      oc_at_done = 8'd0; rt_first = 8'hFF; rs_first = -1; ov_first = -1; re_set = -1;
      last_re_set = -100; re_fall = -100;
      mask4 = m; seq4 = 1'b1; seq_cyc = cyc;
      @(negedge clk); #1 seq4 = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk); #1;
         if (done_cnt > 0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      #1;
      tests++;
      if ({rs4, inlc4, ov4, ol4, busy4, done4, os4, rt4, rj4, ot4, oc4} !== '0) begin
         fails++; $display("FAIL reset_ctrl4: got %0h expected 0",
                           {rs4, inlc4, ov4, ol4, busy4, done4, os4, rt4, rj4, ot4, oc4});
      end
      tests++;
      if (od4 !== '0) begin fails++; $display("FAIL reset_data4: got %0h expected 0", od4); end
      tests++;
      if ({rs1, inlc1, ov1, ol1, busy1, done1, os1, rt1, rj1, ot1, oc1} !== '0 || od1 !== '0) begin
         fails++; $display("FAIL reset_all1: got busy=%0b valid=%0b expected all 0", busy1, ov1);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      bit ok;
      ready_mode = 1'b0; hold_extra = 0;
      start_pass(4'b0101);
      wait_done(ok);
      repeat (3) @(negedge clk);
      #1;
      tests++; if (!ok) begin fails++; $display("FAIL basic_done: got no done expected done pulse"); end
      tests++; if (rs_first - seq_cyc != 2) begin fails++; $display("FAIL basic_start_lat: got %0d expected 2", rs_first - seq_cyc); end
      tests++; if (ov_first - re_set != 1) begin fails++; $display("FAIL basic_beat_lat: got %0d expected 1", ov_first - re_set); end
      tests++; if (bd.size() != 12) begin fails++; $display("FAIL basic_beat_count: got %0d expected 12", bd.size()); end
      for (int i = 0; i < 12 && i < bd.size(); i++) begin
         tests++;
         if (bd[i] !== exp_data(i / 3, i % 3) || bs[i] !== 2'(i % 3) || bt[i] !== 8'(i / 3) || bl[i] !== (i == 11)) begin
            fails++;
            $display("FAIL basic_beat%0d: got t=%0d sel=%0d last=%0b data=%0h expected t=%0d sel=%0d last=%0b data=%0h",
                     i, bt[i], bs[i], bl[i], bd[i], i / 3, i % 3, (i == 11), exp_data(i / 3, i % 3));
         end
      end
      tests++; if (inlc_seen !== 4'b0101) begin fails++; $display("FAIL basic_in_lc: got %b expected 0101", inlc_seen); end
      tests++; if (oc_at_done !== 8'd2) begin fails++; $display("FAIL basic_opened: got %0d expected 2", oc_at_done); end
      tests++; if (done_cnt != 1) begin fails++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
      tests++; if (j_err != 0 || rise_viol != 0) begin fails++; $display("FAIL basic_round_j_spacing: got j_err=%0d rise_viol=%0d expected 0 0", j_err, rise_viol); end
      tests++; if (busy4 !== 1'b0) begin fails++; $display("FAIL basic_busy_after: got %0b expected 0", busy4); end
   endtask

   task automatic test_backpressure();
      bit ok;
      int bad;
      ready_mode = 1'b1; hold_extra = 0;
      start_pass(4'b0101);
      wait_done(ok);
      repeat (3) @(negedge clk);
      #1;
      tests++; if (!ok) begin fails++; $display("FAIL bp_done: got no done expected done pulse"); end
      tests++; if (bd.size() != 12) begin fails++; $display("FAIL bp_beat_count: got %0d expected 12", bd.size()); end
      bad = 0;
      for (int i = 0; i < 12 && i < bd.size(); i++)
         if (bd[i] !== exp_data(i / 3, i % 3) || bs[i] !== 2'(i % 3) || bt[i] !== 8'(i / 3) || bl[i] !== (i == 11)) bad++;
      tests++; if (bad != 0) begin fails++; $display("FAIL bp_beat_order: got %0d wrong beats expected 0", bad); end
      tests++; if (stall_err != 0) begin fails++; $display("FAIL bp_stall_stable: got %0d unstable cycles expected 0", stall_err); end
      tests++; if (oc_at_done !== 8'd2) begin fails++; $display("FAIL bp_opened: got %0d expected 2", oc_at_done); end
      ready_mode = 1'b0;
   endtask

   task automatic test_restart_ignored();
      bit ok, hit;
      int bad;
      ready_mode = 1'b0; hold_extra = 0;
      start_pass(4'b0101);
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk); #1;
         if (rs4 && rt4 == 8'd1) hit = 1'b1;
      end
      tests++; if (!hit) begin fails++; $display("FAIL restart_reach_round1: got no round 1 expected round 1 issue"); end
      mask4 = 4'b1010; seq4 = 1'b1;
      @(negedge clk); #1 seq4 = 1'b0;
      wait_done(ok);
      repeat (30) @(negedge clk);
      #1;
      tests++; if (!ok) begin fails++; $display("FAIL restart_done: got no done expected done pulse"); end
      tests++; if (done_cnt != 1) begin fails++; $display("FAIL restart_done_count: got %0d expected 1", done_cnt); end
      tests++; if (bd.size() != 12) begin fails++; $display("FAIL restart_beat_count: got %0d expected 12", bd.size()); end
      bad = 0;
      for (int i = 0; i < 12 && i < bd.size(); i++)
         if (bs[i] !== 2'(i % 3) || bt[i] !== 8'(i / 3)) bad++;
      tests++; if (bad != 0) begin fails++; $display("FAIL restart_beat_order: got %0d wrong beats expected 0", bad); end
      tests++; if (inlc_seen !== 4'b0101 || oc_at_done !== 8'd2) begin fails++; $display("FAIL restart_mask_held: got lc=%b opened=%0d expected 0101 2", inlc_seen, oc_at_done); end
      tests++; if (busy4 !== 1'b0) begin fails++; $display("FAIL restart_idle_after: got busy=%0b expected 0", busy4); end
   endtask

   task automatic test_release_hold();
      bit ok;
      ready_mode = 1'b0; hold_extra = 5;
      start_pass(4'b0101);
      wait_done(ok);
      repeat (3) @(negedge clk);
      #1;
      tests++; if (!ok) begin fails++; $display("FAIL hold_done: got no done expected done pulse"); end
      tests++; if (rise_viol != 0) begin fails++; $display("FAIL hold_release_wait: got %0d early starts expected 0", rise_viol); end
      tests++; if (bd.size() != 12 || bl[11] !== 1'b1) begin fails++; $display("FAIL hold_beats: got %0d beats expected 12 with last", bd.size()); end
      hold_extra = 0;
   endtask

   task automatic test_reset_midpass();
      bit ok, hit;
      int vseen;
      ready_mode = 1'b0; hold_extra = 0;
      start_pass(4'b0101);
      hit = 1'b0;
      for (int i = 0; i < 400 && !hit; i++) begin
         @(negedge clk); #1;
         if (ov4 && os4 == 2'd1 && ot4 == 8'd2) hit = 1'b1;
      end
      tests++; if (!hit) begin fails++; $display("FAIL rstmid_reach_cn2: got no Cn beat of round 2 expected one"); end
      rst_n = 1'b0;
      #1;
      tests++;
      if ({rs4, inlc4, ov4, ol4, busy4, done4, os4, rt4, rj4, ot4, oc4} !== '0 || od4 !== '0) begin
         fails++; $display("FAIL rstmid_async_clear: got valid=%0b busy=%0b t=%0d opened=%0d expected all 0", ov4, busy4, rt4, oc4);
      end
      @(negedge clk); @(negedge clk); #1 rst_n = 1'b1;
      vseen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         if (ov4 || busy4) vseen++;
      end
      tests++; if (vseen != 0) begin fails++; $display("FAIL rstmid_no_partial: got %0d active cycles expected 0", vseen); end
      start_pass(4'b0101);
      wait_done(ok);
      repeat (3) @(negedge clk);
      #1;
      tests++; if (!ok) begin fails++; $display("FAIL rstmid_restart_done: got no done expected done pulse"); end
      tests++; if (rt_first !== 8'd0 || bd.size() != 12 || bt[0] !== 8'd0) begin fails++; $display("FAIL rstmid_restart_t0: got first t=%0d beats=%0d expected 0 12", rt_first, bd.size()); end
      tests++; if (oc_at_done !== 8'd2) begin fails++; $display("FAIL rstmid_opened: got %0d expected 2", oc_at_done); end
   endtask

   task automatic test_single_round();
      bit seen;
      int dn;
      @(negedge clk); #1 mask1 = 1'b1; seq1 = 1'b1;
      @(negedge clk); #1 seq1 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (rs1) seen = 1'b1;
      end
      tests++; if (!seen) begin fails++; $display("FAIL t1_start: got no round_start expected round_start"); end
      tests++; if (rt1 !== 8'd0 || inlc1 !== 1'b1) begin fails++; $display("FAIL t1_round: got t=%0d lc=%0b expected 0 1", rt1, inlc1); end
      tests++; if (rj1 !== 8'h0B) begin fails++; $display("FAIL t1_round_j: got %0h expected 0b", rj1); end
      #1 re1 = 1'b1;
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         tests++;
         if (ov1 !== 1'b1 || os1 !== 2'(b) || ol1 !== (b == 2) || od1 !== exp_data(0, b)) begin
            fails++; $display("FAIL t1_beat%0d: got valid=%0b sel=%0d last=%0b expected 1 %0d %0b", b, ov1, os1, ol1, b, (b == 2));
         end
         if (b == 0) re1 = 1'b0;
      end
      dn = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done1) dn++;
      end
      tests++; if (dn != 1) begin fails++; $display("FAIL t1_done: got %0d pulses expected 1", dn); end
      tests++; if (oc1 !== 8'd1 || busy1 !== 1'b0) begin fails++; $display("FAIL t1_opened: got opened=%0d busy=%0b expected 1 0", oc1, busy1); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_restart_ignored();
      test_release_hold();
      test_reset_midpass();
      test_single_round();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/verify_round_sequencer.md
# verify_round_sequencer

Drives the per-round verification function over all T parallel repetitions of a Picnic-on-SM4 signature. It issues each round with its index, challenge-list flag and unopened party index, and waits on the round function's start/end handshake. It latches the three 256-bit digests (Ch, Cn, Cv) the round produces and streams them, round by round, to the downstream challenge-hash stage over a valid/ready interface.

## Interface
Parameters
- T, 250: number of parallel repetitions (rounds); 1..255.
- DIGEST_W, 256: digest width.

Ports
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- seq_start  in  1  one-cycle request to begin a full T-round pass; ignored while busy.
- challenge_mask  in  T  bit t = 1 when round t is in the challenge list; sampled at accept.
- j_lookup  in  8  unopened party index for the round currently on round_t (combinational from an external table).
- round_end  in  1  round-function completion flag; held high until round_start drops.
- round_ch, round_cn, round_cv  in  DIGEST_W each  round-function digests, valid while round_end=1.
- round_start  out  1  round-function start level.
- round_t  out  8  current round index.
- round_t_in_LC  out  1  challenge_mask[round_t].
- round_j  out  8  registered j_lookup for the current round.
- out_valid  out  1  digest beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  DIGEST_W  digest beat.
- out_sel  out  2  0=Ch, 1=Cn, 2=Cv.
- out_t  out  8  round index of the beat.
- out_last  out  1  high on the Cv beat of round T-1.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at pass completion.
- opened_count  out  8  number of rounds with t_in_LC=1 issued so far in the current pass.

## Operation
- States: IDLE, LOAD, ISSUE, EMIT_CH, EMIT_CN, EMIT_CV, RELEASE, DONE.
- IDLE: on seq_start, latch challenge_mask, clear round_t and opened_count, set busy, go to LOAD.
- LOAD: register j_lookup into round_j, drive round_t_in_LC, go to ISSUE.
- ISSUE: hold round_start=1. When round_end=1, latch all three digests, drop round_start the same edge, increment opened_count if t_in_LC, go to EMIT_CH.
- EMIT_CH/CN/CV: assert out_valid with the latched digest. Advance on out_valid&&out_ready. From EMIT_CV, go to RELEASE.
- RELEASE: wait for round_end=0. If round_t==T-1, go to DONE. Otherwise increment round_t and go to LOAD.
- DONE: done=1 for one cycle, busy=0, then return to IDLE.
- round_t, round_j and round_t_in_LC stay stable for the whole ISSUE..RELEASE span of a round.
- seq_start while busy has no effect. A new challenge_mask is not sampled mid-pass.
- If round_end is already 1 on entering ISSUE (stale), it is still accepted. The round function guarantees this cannot happen after RELEASE.

## Timing
- Reset value of every output is 0, and the FSM is in IDLE.
- seq_start sampled at cycle 0: LOAD at cycle 1, round_start=1 from cycle 2.
- round_end sampled high at cycle k: round_start=0 and out_valid=1 (Ch) from cycle k+1.
- With out_ready tied high, the three beats occupy cycles k+1..k+3. RELEASE is reached at k+4, and the next round's round_start rises no earlier than k+6.
- Under backpressure, out_data, out_sel, out_t and out_last hold stable while out_valid=1 and out_ready=0. out_valid never drops without a handshake.
- done is asserted in the cycle after the final RELEASE exit. busy falls in that same cycle.
- Reset asserted mid-pass: every output clears asynchronously and the pass is abandoned. No partial beat is completed after reset releases.

## Structure
- Shared package picnic_verify_pkg: T, DIGEST_W, out_sel encodings (SEL_CH=0, SEL_CN=1, SEL_CV=2), state enum.
- One sub-module, digest_emit_buf: a 3-entry latch-and-shift of Ch/Cn/Cv with valid/ready output and sel tagging. The FSM keeps control only.

## Test plan
- T=4, mask=4'b0101, round model asserts round_end 10 cycles after start, out_ready=1 → 12 beats in order Ch,Cn,Cv per t=0..3; round_t_in_LC=1 only for t=0 and t=2; opened_count=2 at done; out_last only on t=3 Cv.
- Same setup with out_ready toggled every other cycle → identical beat sequence; out_data stable across every stalled cycle; no beat lost or duplicated.
- seq_start re-pulsed during round 1 → ignored; exactly 12 beats; one done pulse.
- Round model holds round_end high 5 cycles after round_start drops → RELEASE waits; next round_start rises only after round_end=0.
- Reset pulled low while in EMIT_CN of round 2 → all outputs 0 immediately; after release, a fresh seq_start restarts at t=0 with opened_count=0.
- mask all ones, T=1 → one round with t_in_LC=1, round_j equals j_lookup value 8'h0B, opened_count=1, out_last on the third beat, done pulses.
